// File: rtl/rc_pkg.sv
// Shared types and AXI encodings used by the read responder and its response FIFO.
package rc_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rc_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_8B    = 3'b011;
  localparam int unsigned BEAT_BYTES = 8;

endpackage

// File: rtl/rc_resp_fifo.sv
// Two-entry response FIFO holding {rid, rdata, rresp, rlast}; the head entry
// drives the R channel directly.
module rc_resp_fifo #(
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             not_empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_reg[0] <= '0;
      entry_reg[1] <= '0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
    end else begin
      if (push) begin
        entry_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg            <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign pop_data  = entry_reg[rd_ptr_reg];
  assign not_empty = (count_reg != 2'd0);
  assign count     = count_reg;

endmodule

// File: rtl/rc_axi_read_responder.sv
// AXI4 read-only slave: serves one INCR burst at a time from a synchronous
// 64-bit memory, flagging out-of-range or unsupported beats as SLVERR.
module rc_axi_read_responder
  import rc_pkg::*;
#(
  parameter int          C_S_AXI_ID_WIDTH = 1,
  parameter int          MEM_ADDR_WIDTH   = 12,
  parameter logic [31:0] C_BASE_ADDR      = 32'h0000_0000
) (
  input  logic                        S_AXI_aclk,
  input  logic                        S_AXI_aresetn,
  input  logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_arid,
  input  logic [31:0]                 S_AXI_araddr,
  input  logic [7:0]                  S_AXI_arlen,
  input  logic [2:0]                  S_AXI_arsize,
  input  logic [1:0]                  S_AXI_arburst,
  input  logic                        S_AXI_arvalid,
  output logic                        S_AXI_arready,
  output logic [C_S_AXI_ID_WIDTH-1:0] S_AXI_rid,
  output logic [63:0]                 S_AXI_rdata,
  output logic [1:0]                  S_AXI_rresp,
  output logic                        S_AXI_rlast,
  output logic                        S_AXI_rvalid,
  input  logic                        S_AXI_rready,
  output logic                        mem_en,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  input  logic [63:0]                 mem_rdata,
  output logic                        busy,
  output logic [31:0]                 beats_served
);

  localparam int ENTRY_W = C_S_AXI_ID_WIDTH + 64 + 2 + 1;

  rc_state_t                   state_reg;
  logic                        arready_reg;
  logic [C_S_AXI_ID_WIDTH-1:0] id_reg;
  logic [2:0]                  size_reg;
  logic [1:0]                  burst_reg;
  logic [31:0]                 addr_reg;
  logic [8:0]                  left_reg;
  logic                        pipe_valid_reg;
  logic                        pipe_err_reg;
  logic                        pipe_last_reg;
  logic [31:0]                 served_reg;

  logic               ar_fire;
  logic               r_fire;
  logic [31:0]        beat_off;
  logic [31:0]        beat_word;
  logic               beat_err;
  logic [2:0]         slots_used;
  logic               issue;
  logic [1:0]         fifo_count;
  logic               fifo_not_empty;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;

  assign ar_fire = S_AXI_arvalid & arready_reg;
  assign r_fire  = fifo_not_empty & S_AXI_rready;

  // Addresses below the base wrap to huge offsets and fall out of range.
  assign beat_off  = addr_reg - C_BASE_ADDR;
  assign beat_word = beat_off >> 3;
  assign beat_err  = (size_reg != SIZE_8B) || (burst_reg != BURST_INCR) ||
                     ((beat_word >> MEM_ADDR_WIDTH) != 32'd0);

  // An entry leaving the FIFO this cycle frees its slot, which keeps 1 beat/cycle.
  assign slots_used = {1'b0, fifo_count} + {2'b00, pipe_valid_reg} - {2'b00, r_fire};
  assign issue      = (state_reg == ST_BURST) && (left_reg != 9'd0) && (slots_used < 3'd2);

  assign mem_en   = issue & ~beat_err;
  assign mem_addr = mem_en ? beat_word[MEM_ADDR_WIDTH-1:0] : '0;

  assign push_data = {id_reg,
                      pipe_err_reg ? 64'd0 : mem_rdata,
                      pipe_err_reg ? RESP_SLVERR : RESP_OKAY,
                      pipe_last_reg};

  always_ff @(posedge S_AXI_aclk or negedge S_AXI_aresetn) begin
    if (!S_AXI_aresetn) begin
      state_reg      <= ST_IDLE;
      arready_reg    <= 1'b0;
      id_reg         <= '0;
      size_reg       <= 3'd0;
      burst_reg      <= 2'd0;
      addr_reg       <= 32'd0;
      left_reg       <= 9'd0;
      pipe_valid_reg <= 1'b0;
      pipe_err_reg   <= 1'b0;
      pipe_last_reg  <= 1'b0;
      served_reg     <= 32'd0;
    end else begin
      pipe_valid_reg <= issue;
      pipe_err_reg   <= beat_err;
      pipe_last_reg  <= (left_reg == 9'd1);
      if (r_fire) begin
        served_reg <= served_reg + 32'd1;
      end
      if (issue) begin
        addr_reg <= addr_reg + BEAT_BYTES;
        left_reg <= left_reg - 9'd1;
      end
      case (state_reg)
        ST_IDLE: begin
          arready_reg <= 1'b1;
          if (ar_fire) begin
            id_reg      <= S_AXI_arid;
            addr_reg    <= S_AXI_araddr & ~32'd7;
            size_reg    <= S_AXI_arsize;
            burst_reg   <= S_AXI_arburst;
            left_reg    <= {1'b0, S_AXI_arlen} + 9'd1;
            arready_reg <= 1'b0;
            state_reg   <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (r_fire && S_AXI_rlast) begin
            arready_reg <= 1'b1;
            state_reg   <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  rc_resp_fifo #(
    .WIDTH(ENTRY_W)
  ) u_resp_fifo (
    .clk      (S_AXI_aclk),
    .rst_n    (S_AXI_aresetn),
    .push     (pipe_valid_reg),
    .push_data(push_data),
    .pop      (r_fire),
    .pop_data (head_data),
    .not_empty(fifo_not_empty),
    .count    (fifo_count)
  );

  assign S_AXI_arready = arready_reg;
  assign S_AXI_rvalid  = fifo_not_empty;
  assign {S_AXI_rid, S_AXI_rdata, S_AXI_rresp, S_AXI_rlast} = head_data;
  assign busy          = (state_reg == ST_BURST);
  assign beats_served  = served_reg;

endmodule

// File: tb/tb_rc_axi_read_responder.sv
// Bench for rc_axi_read_responder: table of bursts, hand-written corner
// sequences and random bursts, all checked against a burst-level model.
module tb_rc_axi_read_responder;

  localparam int          IDW  = 4;
  localparam int          MAW  = 12;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [IDW-1:0]  arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [IDW-1:0]  rid;
  logic [63:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic            mem_en;
  logic [MAW-1:0]  mem_addr;
  logic [63:0]     mem_rdata = 64'd0;
  logic            busy;
  logic [31:0]     beats_served;

  int              vectors = 0;
  int              miscompares = 0;
  logic [31:0]     served_model = 32'd0;
  logic [MAW-1:0]  mem_log[$];

  typedef struct {
    logic [IDW-1:0] id;
    logic [63:0]    data;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    addr;
    logic [7:0]     len;
    logic [2:0]     size;
    logic [1:0]     burst;
    int             mode;
    int             exp_ok;
    int             exp_err;
  } vec_t;

  rc_axi_read_responder #(
    .C_S_AXI_ID_WIDTH(IDW),
    .MEM_ADDR_WIDTH  (MAW),
    .C_BASE_ADDR     (BASE)
  ) dut (
    .S_AXI_aclk   (clk),
    .S_AXI_aresetn(rst_n),
    .S_AXI_arid   (arid),
    .S_AXI_araddr (araddr),
    .S_AXI_arlen  (arlen),
    .S_AXI_arsize (arsize),
    .S_AXI_arburst(arburst),
    .S_AXI_arvalid(arvalid),
    .S_AXI_arready(arready),
    .S_AXI_rid    (rid),
    .S_AXI_rdata  (rdata),
    .S_AXI_rresp  (rresp),
    .S_AXI_rlast  (rlast),
    .S_AXI_rvalid (rvalid),
    .S_AXI_rready (rready),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .beats_served (beats_served)
  );

  function automatic logic [63:0] mem_word(input logic [MAW-1:0] w);
    return {20'hD00D5, w, ~{20'h00000, w}};
  endfunction

  // Synchronous memory: data appears one cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      mem_rdata <= mem_word(mem_addr);
      mem_log.push_back(mem_addr);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic run_burst(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input int mode,
                           input int exp_ok, input int exp_err, input bit hold_ar,
                           input logic [IDW-1:0] hold_id, input int abort_after);
    beat_t          exp_q[$];
    logic [MAW-1:0] exp_words[$];
    logic [31:0]    a;
    logic [31:0]    off;
    int             waited, cyc, beats, first_cyc, last_cyc, got_ok, got_err, addr_bad;
    bit             stalled, ar_low_ok;

    // Reference: beat n at aligned base + 8n, erring on size/burst/range rules.
    a = addr & ~32'd7;
    for (int i = 0; i <= int'(len); i++) begin
      beat_t b;
      logic  err;
      off    = a - BASE;
      err    = (size != 3'b011) || (burst != 2'b01) || ((off >> 3) >= (32'd1 << MAW));
      b.id   = id;
      b.resp = err ? 2'b10 : 2'b00;
      b.data = err ? 64'd0 : mem_word(off[MAW+2:3]);
      b.last = (i == int'(len));
      if (!err) exp_words.push_back(off[MAW+2:3]);
      exp_q.push_back(b);
      a = a + 32'd8;
    end
    mem_log.delete();

    arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    waited = 0;
    while (!arready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ar_accept", 64'(arready), 64'd1);
    @(posedge clk); #1;
    if (hold_ar) arid = hold_id;
    else arvalid = 1'b0;

    beats = 0; cyc = 0; first_cyc = -1; last_cyc = -1; got_ok = 0; got_err = 0;
    stalled = 1'b0; ar_low_ok = 1'b1;
    rready = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
    check("busy_on", 64'(busy), 64'd1);
    while (beats <= int'(len) && cyc < 400) begin
      @(negedge clk);
      if (arready) ar_low_ok = 1'b0;
      if (stalled) check("rvalid_hold", 64'(rvalid), 64'd1);
      if (rvalid) begin
        if (first_cyc < 0) first_cyc = cyc;
        check("rid", 64'(rid), 64'(exp_q[beats].id));
        check("rdata", rdata, exp_q[beats].data);
        check("rresp", 64'(rresp), 64'(exp_q[beats].resp));
        check("rlast", 64'(rlast), 64'(exp_q[beats].last));
        if (rready) begin
          if (rresp == 2'b00) got_ok++;
          else got_err++;
          last_cyc = cyc;
          beats++;
          served_model = served_model + 32'd1;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
      cyc++;
      if (abort_after > 0 && beats == abort_after) begin
        rst_n = 1'b0;
        #1;
        check("abort_rvalid", 64'(rvalid), 64'd0);
        check("abort_arready", 64'(arready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_served", 64'(beats_served), 64'd0);
        served_model = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rvalid", 64'(rvalid), 64'd0);
        check("reset_mem_en", 64'(mem_en), 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        rready = 1'b1;
        @(posedge clk); #1;
        check("arready_after_reset", 64'(arready), 64'd1);
        return;
      end
      case (mode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = ($urandom_range(0, 3) != 0);
      endcase
    end

    check("beats_done", 64'(beats), 64'(int'(len) + 1));
    if (mode == 0) begin
      check("first_rvalid_latency", 64'(first_cyc), 64'd2);
      check("last_beat_cycle", 64'(last_cyc), 64'(int'(len) + 2));
    end
    check("arready_low_in_burst", 64'(ar_low_ok), 64'd1);
    check("arready_back", 64'(arready), 64'd1);
    check("busy_off", 64'(busy), 64'd0);
    check("rvalid_idle", 64'(rvalid), 64'd0);
    check("beats_served", 64'(beats_served), 64'(served_model));
    check("mem_en_count", 64'(mem_log.size()), 64'(exp_words.size()));
    addr_bad = 0;
    for (int i = 0; i < exp_words.size() && i < mem_log.size(); i++)
      if (mem_log[i] !== exp_words[i]) addr_bad++;
    check("mem_addr_seq", 64'(addr_bad), 64'd0);
    if (exp_ok >= 0) begin
      check("ok_beats", 64'(got_ok), 64'(exp_ok));
      check("err_beats", 64'(got_err), 64'(exp_err));
    end
    rready = 1'b1;
  endtask

  vec_t table_v[8];

  initial begin
    table_v[0] = '{4'h3, BASE + 32'h40,   8'd15, 3'b011, 2'b01, 0, 16, 0};
    table_v[1] = '{4'h3, BASE + 32'h40,   8'd15, 3'b011, 2'b01, 1, 16, 0};
    table_v[2] = '{4'h7, BASE + 32'h7FF0, 8'd3,  3'b011, 2'b01, 0, 2,  2};
    table_v[3] = '{4'h1, BASE + 32'h100,  8'd1,  3'b010, 2'b01, 0, 0,  2};
    table_v[4] = '{4'h2, BASE + 32'h10,   8'd2,  3'b011, 2'b00, 1, 0,  3};
    table_v[5] = '{4'h9, BASE - 32'd8,    8'd1,  3'b011, 2'b01, 0, 1,  1};
    table_v[6] = '{4'h4, BASE + 32'h5,    8'd0,  3'b011, 2'b01, 2, 1,  0};
    table_v[7] = '{4'hF, 32'hFFFF_FFF8,   8'd1,  3'b011, 2'b01, 2, 0,  2};

    rst_n = 1'b0; arvalid = 1'b0; arid = '0; araddr = 32'd0; arlen = 8'd0;
    arsize = 3'd0; arburst = 2'd0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_rpayload", 64'({rlast, rresp, rid}), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_mem", 64'({mem_en, mem_addr}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_beats_served", 64'(beats_served), 64'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    rready = 1'b1;
    @(posedge clk); #1;
    check("arready_first_cycle", 64'(arready), 64'd1);

    for (int v = 0; v < 8; v++)
      run_burst(table_v[v].id, table_v[v].addr, table_v[v].len, table_v[v].size,
                table_v[v].burst, table_v[v].mode, table_v[v].exp_ok, table_v[v].exp_err,
                1'b0, 4'h0, 0);

    // AR held valid through a burst; the second burst gets its own rid.
    run_burst(4'h6, BASE + 32'h200, 8'd7, 3'b011, 2'b01, 0, 8, 0, 1'b1, 4'hA, 0);
    run_burst(4'hA, BASE + 32'h200, 8'd7, 3'b011, 2'b01, 0, 8, 0, 1'b0, 4'h0, 0);

    // Reset after beat 5 of 16, then a fresh burst from beat 0.
    run_burst(4'h3, BASE + 32'h40, 8'd15, 3'b011, 2'b01, 0, -1, -1, 1'b0, 4'h0, 5);
    run_burst(4'h5, BASE + 32'h40, 8'd15, 3'b011, 2'b01, 0, 16, 0, 1'b0, 4'h0, 0);

    for (int r = 0; r < 25; r++) begin
      logic [31:0] ra;
      logic [2:0]  rs;
      logic [1:0]  rb;
      if ($urandom_range(0, 9) == 0) ra = $urandom();
      else ra = BASE + 32'($urandom_range(0, 4100)) * 32'd8 + 32'($urandom_range(0, 7));
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b011;
      rb = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
      run_burst(4'($urandom_range(0, 15)), ra, 8'($urandom_range(0, 15)), rs, rb,
                int'($urandom_range(0, 2)), -1, -1, 1'b0, 4'h0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rc_axi_read_responder.md
RC_AXI_READ_RESPONDER -- requirements
Module: rc_axi_read_responder

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1, meaning width of arid/rid.
REQ-002 SHALL have parameter MEM_ADDR_WIDTH, default 12, meaning 64-bit word-address width of the backing memory.
REQ-003 SHALL have parameter C_BASE_ADDR, default 32'h0000_0000, meaning byte address mapped to memory word 0.
REQ-004 S_AXI_aclk  in  1  sole clock; all logic rising-edge.
REQ-005 S_AXI_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-006 S_AXI_arid/araddr/arlen/arsize/arburst  in  ID/32/8/3/2  AXI4 read address payload.
REQ-007 S_AXI_arvalid  in  1; S_AXI_arready  out  1  AR handshake.
REQ-008 S_AXI_rid/rdata/rresp/rlast  out  ID/64/2/1  AXI4 read data payload.
REQ-009 S_AXI_rvalid  out  1; S_AXI_rready  in  1  R handshake.
REQ-010 mem_en  out  1; mem_addr  out  MEM_ADDR_WIDTH; mem_rdata  in  64  synchronous memory read port, data valid exactly 1 cycle after mem_en.
REQ-011 busy  out  1  high while a burst is accepted and not fully delivered; beats_served  out  32  count of completed R handshakes.

Function
REQ-012 SHALL serve one outstanding read burst; FSM states IDLE and BURST.
REQ-013 IDLE: arready=1; on arvalid&arready latch arid, araddr&~7, arlen, arsize, arburst; beats_left=arlen+1; go to BURST next cycle.
REQ-014 BURST: arready=0; return to IDLE the cycle after the R handshake with rlast=1; no AR accepted in the same cycle.
REQ-015 Beat n address SHALL be latched_addr + 8*n, 32-bit wrap-around, regardless of arburst.
REQ-016 Beat error SHALL be flagged when arsize!=3'b011, arburst!=2'b01, or (addr-C_BASE_ADDR)>>3 >= 2**MEM_ADDR_WIDTH (unsigned; addr below base also errs via wrap).
REQ-017 Errored beat: rresp=2'b10 (SLVERR), rdata=0, no mem_en; good beat: rresp=2'b00, rdata=mem_rdata, mem_addr=(addr-C_BASE_ADDR)>>3.
REQ-018 Exactly arlen+1 beats SHALL be returned, rlast=1 only on the final beat, rid=latched arid on every beat.
REQ-019 Read data SHALL pass through a 2-entry response FIFO; a beat is issued (mem_en or error entry) only when FIFO occupancy plus in-flight issues < 2.
REQ-020 With rready held high, throughput SHALL be 1 beat/cycle; first rvalid 2 cycles after AR handshake.
REQ-021 rvalid and R payload SHALL stay stable while rvalid=1 and rready=0.
REQ-022 FIFO simultaneous push and pop at occupancy 2 SHALL not occur (credit rule); at occupancy 1, push+pop keeps occupancy 1.
REQ-023 beats_served SHALL increment on each rvalid&rready, wrapping 2^32-1 -> 0.
REQ-024 busy SHALL equal (state==BURST).

Reset
REQ-025 During reset: arready=0, rvalid=0, rlast=0, rresp=0, rdata=0, rid=0, mem_en=0, mem_addr=0, busy=0, beats_served=0, FIFO empty, state IDLE.
REQ-026 arready SHALL rise the first clock after reset deassertion.
REQ-027 Reset asserted mid-burst SHALL abort immediately; in-flight memory data discarded; no further R beats.

Structure
REQ-028 Shared package rc_pkg SHALL hold the FSM typedef, AXI resp constants (OKAY, SLVERR), burst/size encodings and beat size 8.
REQ-029 Response FIFO SHALL be sub-module rc_resp_fifo (depth 2, width ID+64+2+1, async active-low reset).

Verification
REQ-030 araddr=C_BASE_ADDR+0x40, arlen=15, INCR, size 3, rready=1 -> 16 OKAY beats, mem_addr 8..23, rlast on beat 16, beats_served=16.
REQ-031 Same burst with rready toggled 1/0 each cycle -> payload stable while stalled, no beat lost/duplicated, 16 beats.
REQ-032 arlen=3 starting at word 4094 (MEM_ADDR_WIDTH=12) -> beats 0-1 OKAY, beats 2-3 SLVERR with rdata=0, no mem_en for 2-3.
REQ-033 arsize=3'b010, arlen=1 -> 2 SLVERR beats, rlast on second, mem_en never asserted.
REQ-034 arvalid held during BURST -> arready=0 until cycle after final beat, second burst served correctly with its own rid.
REQ-035 Reset asserted after beat 5 of 16 -> rvalid=0 immediately, arready=1 first cycle after release, next burst served from beat 0.
